// File: rtl/qa_stream_checker.sv
// Scoreboard for the QA buffer wrapper output stream: checks an arithmetic word sequence and error codes.
// Latency 1 cycle from in_nd to verdict; no backpressure (every in_nd word is consumed).
module qa_stream_checker #(
    parameter int              WDTH        = 32,
    parameter logic [WDTH-1:0] SEED        = '0,
    parameter logic [WDTH-1:0] STEP        = WDTH'(1),
    parameter int              N_WORDS     = 16,
    parameter int              CNT_W       = 16,
    parameter int              TIMEOUT     = 1024,
    parameter logic [WDTH-1:0] WR_ERR_CODE = WDTH'(32'hFFFF0001),
    parameter logic [WDTH-1:0] RD_ERR_CODE = WDTH'(32'hFFFF0002)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WDTH-1:0]  in_data,
    input  logic             in_nd,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       fail_cause,
    output logic [CNT_W-1:0] word_count,
    output logic [WDTH-1:0]  bad_data,
    output logic [WDTH-1:0]  exp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_MISMATCH = 3'd1;
    localparam logic [2:0] C_WR_ERR   = 3'd2;
    localparam logic [2:0] C_RD_ERR   = 3'd3;
    localparam logic [2:0] C_TIMEOUT  = 3'd4;
    localparam logic [2:0] C_OVERRUN  = 3'd5;

    // Wide enough to hold TIMEOUT; with the timeout disabled it just saturates.
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'(N_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wc_q, wc_d, wc_inc;
    logic [WDTH-1:0]   exp_q, exp_d;
    logic [WDTH-1:0]   bad_q, bad_d;
    logic [2:0]        cause_q, cause_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    assign wc_inc = wc_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        exp_d   = exp_q;
        bad_d   = bad_q;
        cause_d = cause_q;
        idle_d  = idle_q;
        if (start) begin
            state_d = S_RUN;
            wc_d    = '0;
            exp_d   = SEED;
            bad_d   = '0;
            cause_d = C_NONE;
            idle_d  = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (in_nd) begin
                        idle_d = '0;
                        if (in_data == WR_ERR_CODE) begin
                            state_d = S_FAIL;
                            cause_d = C_WR_ERR;
                            bad_d   = in_data;
                        end else if (in_data == RD_ERR_CODE) begin
                            state_d = S_FAIL;
                            cause_d = C_RD_ERR;
                            bad_d   = in_data;
                        end else if (in_data != exp_q) begin
                            state_d = S_FAIL;
                            cause_d = C_MISMATCH;
                            bad_d   = in_data;
                        end else begin
                            wc_d  = wc_inc;
                            exp_d = exp_q + STEP;
                            if (wc_inc == N_LAST) begin
                                state_d = S_PASS;
                            end
                        end
                    end else begin
                        if (idle_q != '1) begin
                            idle_d = idle_q + IDLE_W'(1);
                        end
                        if (TIMEOUT != 0 && idle_q == IDLE_LAST) begin
                            state_d = S_FAIL;
                            cause_d = C_TIMEOUT;
                        end
                    end
                end
                S_PASS: begin
                    if (in_nd) begin
                        state_d = S_FAIL;
                        cause_d = C_OVERRUN;
                        bad_d   = in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            exp_q   <= '0;
            bad_q   <= '0;
            cause_q <= C_NONE;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            exp_q   <= exp_d;
            bad_q   <= bad_d;
            cause_q <= cause_d;
            idle_q  <= idle_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign pass       = (state_q == S_PASS);
    assign fail       = (state_q == S_FAIL);
    assign fail_cause = cause_q;
    assign word_count = wc_q;
    assign bad_data   = bad_q;
    assign exp_data   = exp_q;

endmodule

// File: tb/tb_qa_stream_checker.sv
// Directed bench: dut_a (SEED 0, N_WORDS 4, TIMEOUT 8) and dut_b (SEED FFFFFFFE, N_WORDS 4, timeout off).
module tb_qa_stream_checker;

    logic        clk = 1'b0;
    logic        reset, start, in_nd;
    logic [31:0] in_data;

    logic        a_busy, a_pass, a_fail, b_busy, b_pass, b_fail;
    logic [2:0]  a_cause, b_cause;
    logic [15:0] a_wc, b_wc;
    logic [31:0] a_bad, a_exp, b_bad, b_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qa_stream_checker #(.SEED(32'h0), .STEP(32'h1), .N_WORDS(4), .TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_nd(in_nd),
        .busy(a_busy), .pass(a_pass), .fail(a_fail), .fail_cause(a_cause),
        .word_count(a_wc), .bad_data(a_bad), .exp_data(a_exp));

    qa_stream_checker #(.SEED(32'hFFFFFFFE), .STEP(32'h1), .N_WORDS(4), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_nd(in_nd),
        .busy(b_busy), .pass(b_pass), .fail(b_fail), .fail_cause(b_cause),
        .word_count(b_wc), .bad_data(b_bad), .exp_data(b_exp));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w);
        in_nd   = 1'b1;
        in_data = w;
        tick(1);
        in_nd   = 1'b0;
        in_data = 32'h0;
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic bsy, input logic ps, input logic fl,
                         input logic [2:0] cause, input logic [15:0] wc,
                         input logic [31:0] bad, input logic [31:0] exp);
        chk({tag, ".busy"},  32'(a_busy),  32'(bsy));
        chk({tag, ".pass"},  32'(a_pass),  32'(ps));
        chk({tag, ".fail"},  32'(a_fail),  32'(fl));
        chk({tag, ".cause"}, 32'(a_cause), 32'(cause));
        chk({tag, ".wc"},    32'(a_wc),    32'(wc));
        chk({tag, ".bad"},   a_bad,        bad);
        chk({tag, ".exp"},   a_exp,        exp);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_nd = 1'b0; in_data = 32'h0;
        tick(3);
        reset = 1'b0;
        chk_a("reset", 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Clean run with gaps; verdict one cycle after the last word.
        go();
        chk_a("t1.start", 1, 0, 0, 0, 0, 32'h0, 32'h0);
        send(32'd0); tick(2);
        send(32'd1); tick(1);
        send(32'd2);
        chk_a("t1.w2", 1, 0, 0, 0, 3, 32'h0, 32'd3);
        tick(3);
        send(32'd3);
        chk_a("t1.pass", 0, 1, 0, 0, 4, 32'h0, 32'd4);

        // Overrun after pass.
        send(32'd5);
        chk_a("t5.overrun", 0, 0, 1, 5, 4, 32'd5, 32'd4);

        // Mismatch, then FAIL absorbs further words.
        go();
        send(32'd0); send(32'd1); send(32'd7);
        chk_a("t2.mismatch", 0, 0, 1, 1, 2, 32'd7, 32'd2);
        send(32'd2); tick(12);
        chk_a("t2.hold", 0, 0, 1, 1, 2, 32'd7, 32'd2);

        // Upstream error codes as word 0.
        go();
        send(32'hFFFF0001);
        chk_a("t3.wr", 0, 0, 1, 2, 0, 32'hFFFF0001, 32'h0);
        go();
        send(32'hFFFF0002);
        chk_a("t3.rd", 0, 0, 1, 3, 0, 32'hFFFF0002, 32'h0);

        // Timeout: 7 idle cycles still running, 8th idle cycle trips it.
        go();
        tick(7);
        chk_a("t5.idle7", 1, 0, 0, 0, 0, 32'h0, 32'h0);
        tick(1);
        chk_a("t5.timeout", 0, 0, 1, 4, 0, 32'h0, 32'h0);

        // Wrapping sequence on dut_b.
        go();
        chk("t4.exp0", b_exp, 32'hFFFFFFFE);
        send(32'hFFFFFFFE); send(32'hFFFFFFFF);
        chk("t4.expwrap", b_exp, 32'h0);
        send(32'h0);
        chk("t4.busy", 32'(b_busy), 32'd1);
        send(32'h1);
        chk("t4.pass", 32'(b_pass), 32'd1);
        chk("t4.fail", 32'(b_fail), 32'd0);
        chk("t4.wc", 32'(b_wc), 32'd4);
        chk("t4.exp", b_exp, 32'd2);

        // Timeout disabled on dut_b: long idle keeps it running.
        go();
        tick(40);
        chk("t4.noto.busy", 32'(b_busy), 32'd1);
        chk("t4.noto.fail", 32'(b_fail), 32'd0);
        chk("t4.noto.cause", 32'(b_cause), 32'd0);

        // Reset mid-run, then start and in_nd in the same cycle.
        go();
        send(32'd0); send(32'd1);
        chk("t6.pre.wc", 32'(a_wc), 32'd2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_a("t6.reset", 0, 0, 0, 0, 0, 32'h0, 32'h0);
        start = 1'b1; in_nd = 1'b1; in_data = 32'h0;
        tick(1);
        start = 1'b0; in_nd = 1'b0;
        chk_a("t6.startnd", 1, 0, 0, 0, 0, 32'h0, 32'h0);
        send(32'd0);
        chk_a("t6.next", 1, 0, 0, 0, 1, 32'h0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
